// File: rtl/sram_arbiter.sv
// sram_arbiter: two-master arbiter and access sequencer for the single-port sram.
// Grants one picorv32-style master at a time, strobes sram_sel for one cycle,
// waits for sram_ready (or a watchdog expiry) and returns completion/rdata.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin tie-break);
// undefined gives fixed priority with m0 winning.
module sram_arbiter #(
   parameter int unsigned ADDRWIDTH = 13,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 m0_valid,
   input  logic [31:0]          m0_addr,
   input  logic [31:0]          m0_wdata,
   input  logic [3:0]           m0_wstrb,
   output logic                 m0_ready,
   output logic [31:0]          m0_rdata,
   input  logic                 m1_valid,
   input  logic [31:0]          m1_addr,
   input  logic [31:0]          m1_wdata,
   input  logic [3:0]           m1_wstrb,
   output logic                 m1_ready,
   output logic [31:0]          m1_rdata,
   output logic                 sram_sel,
   output logic [ADDRWIDTH-1:0] sram_addr,
   output logic [3:0]           sram_wstrb,
   output logic [31:0]          sram_wdata,
   input  logic                 sram_ready,
   input  logic [31:0]          sram_rdata,
   output logic                 timeout_err
);

   localparam int unsigned WDOG_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t               state;
   logic                 grant;
   logic                 sel_q;
   logic [ADDRWIDTH-1:0] addr_q;
   logic [31:0]          wdata_q;
   logic [3:0]           wstrb_q;
   logic [WDOG_W-1:0]    wdog;

   logic                 any_valid;
   logic                 winner;
   logic                 expired;
   logic                 done;
   logic [31:0]          ret_data;

   // Address bits above the SRAM window are intentionally ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{m0_addr[31:ADDRWIDTH], m1_addr[31:ADDRWIDTH]};

   assign any_valid = m0_valid | m1_valid;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   // Winner select: ties go to the master rr_ptr prefers, lone requests always win
   always_comb begin
      winner = m1_valid;
      if (m0_valid && m1_valid) begin
         winner = rr_ptr;
      end
   end

   // Preference flips to the master not granted on every grant
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr <= 1'b0;
      end else if (state == S_IDLE && any_valid) begin
         rr_ptr <= ~winner;
      end
   end
`else
   // Winner select: fixed priority, m0 wins whenever it is valid
   always_comb begin
      winner = ~m0_valid;
   end
`endif

   // Sequencer: latch request in IDLE, strobe in REQ, wait for ready or watchdog
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= S_IDLE;
         grant   <= 1'b0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         wdog    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  grant   <= winner;
                  addr_q  <= winner ? m1_addr[ADDRWIDTH-1:0] : m0_addr[ADDRWIDTH-1:0];
                  wdata_q <= winner ? m1_wdata : m0_wdata;
                  wstrb_q <= winner ? m1_wstrb : m0_wstrb;
                  sel_q   <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               sel_q <= 1'b0;
               wdog  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (sram_ready || expired) begin
                  state <= S_IDLE;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               sel_q <= 1'b0;
            end
         endcase
      end
   end

   assign expired    = (wdog == WDOG_W'(TIMEOUT));
   assign done       = resetn && (state == S_WAIT) && (sram_ready || expired);
   assign ret_data   = sram_ready ? sram_rdata : 32'h0;

   assign sram_sel   = sel_q;
   assign sram_addr  = addr_q;
   assign sram_wstrb = wstrb_q;
   assign sram_wdata = wdata_q;

   // Completion steering: only the granted master sees ready and data
   always_comb begin
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      m0_rdata    = 32'h0;
      m1_rdata    = 32'h0;
      timeout_err = 1'b0;
      if (done) begin
         timeout_err = ~sram_ready;
         if (grant) begin
            m1_ready = 1'b1;
            m1_rdata = ret_data;
         end else begin
            m0_ready = 1'b1;
            m0_rdata = ret_data;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a behavioural sram model.
module tb_sram_arbiter;

   localparam int unsigned AW = 13;

   logic          clk = 1'b0;
   logic          resetn;
   logic          m0_valid, m1_valid;
   logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic          m0_ready, m1_ready;
   logic [31:0]   m0_rdata, m1_rdata;
   logic          sram_sel;
   logic [AW-1:0] sram_addr;
   logic [3:0]    sram_wstrb;
   logic [31:0]   sram_wdata;
   logic          sram_ready;
   logic [31:0]   sram_rdata;
   logic          timeout_err;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDRWIDTH(AW), .TIMEOUT(15)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .sram_sel(sram_sel), .sram_addr(sram_addr), .sram_wstrb(sram_wstrb),
      .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
      .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic        m;
      logic        tmo;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   bit          stall = 1'b0;
   bit          preloaded = 1'b0;
   logic [31:0] mem     [2048];
   logic [31:0] ref_mem [2048];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] ws);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] pattern(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Single-port sram: registered ready, write-through read data
   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 2048; i++) mem[i] <= pattern(i);
         preloaded  <= 1'b1;
         sram_ready <= 1'b0;
      end else begin
         sram_ready <= sram_sel & ~stall;
         if (sram_sel) begin
            mem[sram_addr[12:2]] <= merge(mem[sram_addr[12:2]], sram_wdata, sram_wstrb);
            sram_rdata           <= merge(mem[sram_addr[12:2]], sram_wdata, sram_wstrb);
         end
      end
   end

   // Completion monitor: every ready pulse pops one scoreboard entry
   always @(negedge clk) begin
      if (m0_ready || m1_ready) begin
         check("ready_onehot", 32'(m0_ready & m1_ready), 32'd0);
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("grant", 32'(m1_ready), 32'(mon_e.m));
            check("rdata", m1_ready ? m1_rdata : m0_rdata, mon_e.rdata);
            check("other_rdata", m1_ready ? m0_rdata : m1_rdata, 32'h0);
            check("timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
         end
      end else begin
         check("tmo_without_ready", 32'(timeout_err), 32'd0);
      end
   end

   task automatic drive(input bit m, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws);
      if (m) begin
         m1_valid = 1'b1; m1_addr = addr; m1_wdata = wd; m1_wstrb = ws;
      end else begin
         m0_valid = 1'b1; m0_addr = addr; m0_wdata = wd; m0_wstrb = ws;
      end
   endtask

   task automatic push_exp(input bit m, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input bit tmo);
      exp_t e;
      logic [31:0] w;
      w = merge(ref_mem[addr[12:2]], wd, ws);
      ref_mem[addr[12:2]] = w;
      e.m     = m;
      e.tmo   = tmo;
      e.rdata = tmo ? 32'h0 : w;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input bit m, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m ? m1_ready : m0_ready) && n < 64);
   endtask

   // One isolated access from an idle arbiter, with strobe/latch/latency checks
   task automatic access(input bit m, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input bit tmo, input int exp_lat);
      int  n;
      bit  got;
      logic [AW-1:0] a;
      a = addr[AW-1:0];
      @(negedge clk);
      push_exp(m, addr, wd, ws, tmo);
      drive(m, addr, wd, ws);
      n   = 0;
      got = 1'b0;
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("sel_strobe", 32'(sram_sel), 32'd1);
            check("sram_addr", 32'(sram_addr), 32'(a));
            check("sram_wdata", sram_wdata, wd);
            check("sram_wstrb", 32'(sram_wstrb), 32'(ws));
         end else begin
            check("sel_single", 32'(sram_sel), 32'd0);
         end
         got = m ? m1_ready : m0_ready;
      end
      check("latency", 32'(n), 32'(exp_lat));
      if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int cnt;
      for (int i = 0; i < 2048; i++) ref_mem[i] = pattern(i);
      resetn   = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h0; m1_wstrb = 4'h0;

      // Reset held with both valids high
      repeat (2) begin
         @(negedge clk);
         check("rst_sel", 32'(sram_sel), 32'd0);
         check("rst_m0_ready", 32'(m0_ready), 32'd0);
         check("rst_m1_ready", 32'(m1_ready), 32'd0);
         check("rst_tmo", 32'(timeout_err), 32'd0);
         check("rst_addr", 32'(sram_addr), 32'd0);
         check("rst_m0_rdata", m0_rdata, 32'h0);
      end
      push_exp(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
      push_exp(1'b1, 32'h44, 32'h0, 4'h0, 1'b0);
      resetn = 1'b1;
      wait_ready(1'b0, n);
      check("rst_m0_first_lat", 32'(n), 32'd2);
      m0_valid = 1'b0;
      wait_ready(1'b1, n);
      check("rst_m1_next_lat", 32'(n), 32'd3);
      m1_valid = 1'b0;

      // Full write then readback
      access(1'b0, 32'h10, 32'hA5A5_1234, 4'hF, 1'b0, 2);
      access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 2);

      // Byte-lane merge
      access(1'b0, 32'h20, 32'h1111_1111, 4'hF, 1'b0, 2);
      access(1'b0, 32'h20, 32'h0000_FF00, 4'b0010, 1'b0, 2);
      access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 2);

      // Upper address bits ignored; last grant to m1 leaves preference on m0
      access(1'b0, 32'hFFFF_E030, 32'h600D_F00D, 4'hF, 1'b0, 2);
      access(1'b1, 32'h30, 32'h0, 4'h0, 1'b0, 2);

      // Both masters continuously valid for six completions
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         if (i % 2 == 0) push_exp(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
         else            push_exp(1'b1, 32'h104, 32'h0, 4'h0, 1'b0);
`else
         push_exp(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
`endif
      end
      drive(1'b0, 32'h100, 32'h0, 4'h0);
      drive(1'b1, 32'h104, 32'h0, 4'h0);
      cnt = 0;
      n   = 0;
      while (cnt < 6 && n < 100) begin
         @(negedge clk);
         n++;
         if (m0_ready || m1_ready) cnt++;
      end
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      check("pair_count", 32'(cnt), 32'd6);
      check("pair_cycles", 32'(n), 32'd17);

      // Watchdog: no sram_ready, forced completion 16 cycles after REQ
      stall = 1'b1;
      access(1'b1, 32'h50, 32'h0, 4'h0, 1'b1, 17);
      stall = 1'b0;

      // Reset during WAIT aborts the access silently
      @(negedge clk);
      stall = 1'b1;
      drive(1'b0, 32'h60, 32'h0, 4'h0);
      repeat (4) @(negedge clk);
      check("wait_sel", 32'(sram_sel), 32'd0);
      check("wait_addr_stable", 32'(sram_addr), 32'h60);
      resetn   = 1'b0;
      m0_valid = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(m0_ready | m1_ready), 32'd0);
      check("abort_addr", 32'(sram_addr), 32'd0);
      check("abort_sel", 32'(sram_sel), 32'd0);
      resetn = 1'b1;
      stall  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_abort_quiet", 32'(m0_ready | m1_ready | timeout_err), 32'd0);
      end
      access(1'b0, 32'h60, 32'h0, 4'h0, 1'b0, 2);

      @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
